fetch_unit: RTL and testbench

Parametrised instruction-fetch stage, successor to the fixed PC+4 fetch block. Holds the PC and issues word requests to instruction memory over a valid/ready request and valid response interface, one request outstanding. Buffers returned instructions with their PCs in a small FIFO toward decode. Supports backpressure from decode and PC redirect (branch/jump) with flush and discard of an in-flight response.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_buffer.sv | 64 ++++++
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its fetch buffer.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,  // nothing outstanding
        ST_WAIT  = 2'd1,  // one request outstanding, response wanted
        ST_DROP  = 2'd2   // one request outstanding, response to be discarded
    } fetch_state_e;

    localparam int DEFAULT_INSTR_BYTES = 4;

    // A buffered fetch entry is {pc, instruction}.
    function automatic int entry_width(input int xlen, input int ilen);
        return xlen + ilen;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO between fetch and decode; wrap-bit pointers give full/empty/count.
module fetch_buffer #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         push_data_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [WIDTH-1:0]         head_data_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o     = (wr_ptr_q == rd_ptr_q);
    assign full_o      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o     = wr_ptr_q - rd_ptr_q;
    assign head_data_o = mem_q[rd_ptr_q[AW-1:0]];

    // A push into a full buffer is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && (!full_o || do_pop) && !flush_i;

    always_comb begin
        // NOTE: defaults first so no path leaves a _d signal unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments for every register so all flops update together.
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC sequencing, single-outstanding memory requests,
// redirect with in-flight response discard, and a small buffer toward decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN        = 64,
    parameter int              ILEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              BUF_DEPTH   = 2,
    parameter int              INSTR_BYTES = DEFAULT_INSTR_BYTES
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_resp_valid,
    input  logic [ILEN-1:0] mem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [ILEN-1:0] if_instr
);

    localparam int              EW         = entry_width(XLEN, ILEN);
    localparam int              CW         = $clog2(BUF_DEPTH) + 1;
    localparam int              OFF_BITS   = $clog2(INSTR_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = {XLEN{1'b1}} << OFF_BITS;
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INSTR_BYTES);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] req_pc_q;

    logic            buf_full;
    logic            buf_empty;
    logic [CW-1:0]   buf_count;
    logic [EW-1:0]   buf_head;

    logic            resp_take;
    logic            push;
    logic            pop;
    logic            can_issue_state;
    logic [CW:0]     occupancy;
    logic            credit;
    logic            req_fire;

    // Redirect kills the head combinationally so decode never sees a stale instruction.
    assign if_valid = !buf_empty && !redirect_valid;
    assign pop      = if_valid && if_ready;
    assign if_pc    = buf_head[EW-1 -: XLEN];
    assign if_instr = buf_head[ILEN-1:0];

    assign resp_take = (state_q == ST_WAIT) && mem_resp_valid;
    assign push      = resp_take && !redirect_valid && (!buf_full || pop);

    // Buffered entries plus the wanted in-flight response, net of this cycle's pop.
    // A response landing this cycle moves from in-flight to buffered, so it counts once.
    assign occupancy = {1'b0, buf_count}
                     + {{CW{1'b0}}, (state_q == ST_WAIT)}
                     - {{CW{1'b0}}, pop};
    assign credit    = occupancy < (CW+1)'(BUF_DEPTH);

    assign can_issue_state = (state_q == ST_FETCH) || resp_take;
    assign mem_req_valid   = !reset && !redirect_valid && can_issue_state && credit;
    assign mem_req_addr    = pc_q;
    assign req_fire        = mem_req_valid && mem_req_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= redirect_pc & ALIGN_MASK;
            // A response arriving now is the one in flight; with it gone nothing is left to drop.
            if (state_q != ST_FETCH && !mem_resp_valid) state_q <= ST_DROP;
            else                                        state_q <= ST_FETCH;
        end else begin
            if (req_fire) begin
                req_pc_q <= pc_q;
                pc_q     <= pc_q + PC_STEP;
            end
            unique case (state_q)
                ST_FETCH: if (req_fire) state_q <= ST_WAIT;
                ST_WAIT:  if (mem_resp_valid) state_q <= req_fire ? ST_WAIT : ST_FETCH;
                ST_DROP:  if (mem_resp_valid) state_q <= ST_FETCH;
                default:  state_q <= ST_FETCH;
            endcase
        end
    end

    fetch_buffer #(
        .WIDTH (EW),
        .DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .push_data_i ({req_pc_q, mem_resp_data}),
        .full_o      (buf_full),
        .empty_o     (buf_empty),
        .count_o     (buf_count),
        .head_data_o (buf_head)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// against a transaction-level model of the fetch stream.
module tb_fetch_unit;

    localparam int          XLEN    = 64;
    localparam int          ILEN    = 32;
    localparam int          DEPTH   = 2;
    localparam logic [63:0] RPC     = 64'h1000;
    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT
    logic            reset = 1'b1;
    logic            mem_req_valid;
    logic            mem_req_ready = 1'b0;
    logic [63:0]     mem_req_addr;
    logic            mem_resp_valid = 1'b0;
    logic [31:0]     mem_resp_data = '0;
    logic            redirect_valid = 1'b0;
    logic [63:0]     redirect_pc = '0;
    logic            if_valid;
    logic            if_ready = 1'b0;
    logic [63:0]     if_pc;
    logic [31:0]     if_instr;

    // Wrap-around DUT
    logic            w_reset = 1'b1;
    logic            w_req_valid;
    logic            w_req_ready = 1'b1;
    logic [63:0]     w_req_addr;
    logic            w_resp_valid = 1'b0;
    logic [31:0]     w_resp_data = '0;
    logic            w_if_valid;
    logic [63:0]     w_if_pc;
    logic [31:0]     w_if_instr;

    fetch_unit #(.XLEN(XLEN), .ILEN(ILEN), .RESET_PC(RPC), .BUF_DEPTH(DEPTH), .INSTR_BYTES(4)) dut (
        .clk(clk), .reset(reset),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr)
    );

    fetch_unit #(.XLEN(XLEN), .ILEN(ILEN), .RESET_PC(WRAP_PC), .BUF_DEPTH(DEPTH), .INSTR_BYTES(4)) dut_wrap (
        .clk(clk), .reset(w_reset),
        .mem_req_valid(w_req_valid), .mem_req_ready(w_req_ready), .mem_req_addr(w_req_addr),
        .mem_resp_valid(w_resp_valid), .mem_resp_data(w_resp_data),
        .redirect_valid(1'b0), .redirect_pc(64'h0),
        .if_valid(w_if_valid), .if_ready(1'b1), .if_pc(w_if_pc), .if_instr(w_if_instr)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: expected decode stream and next fetch address.
    typedef struct { logic [63:0] pc; logic [31:0] instr; } ent_t;
    ent_t        q[$];
    logic [63:0] m_pc = RPC;
    bit          m_out = 0;
    bit          m_kill = 0;
    logic [63:0] m_out_addr = '0;

    // Memory model
    bit          mem_pend = 0;
    logic [63:0] mem_addr = '0;
    int          mem_wait = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    bit          spur_en = 0;

    // Values sampled in the current cycle
    logic        s_req_valid, s_if_valid;
    logic [63:0] s_req_addr, s_if_pc;
    logic [31:0] s_if_instr;
    int          handshakes = 0;
    int          pops = 0;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ {a[47:32], a[63:48]} ^ 32'h1357_9BDF;
    endfunction

    task automatic model_reset();
        q.delete();
        m_pc   = RPC;
        m_out  = 0;
        m_kill = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        redirect_valid = 1'b0; if_ready = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        model_reset();
        mem_pend = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock cycle: drive inputs at the falling edge, sample, compare with the model, advance it.
    task automatic step(input bit redir, input logic [63:0] rpc, input bit ifr, input bit mrdy);
        bit resp_now, resp_hit, exp_if_v, exp_req_v, pop_m, can_st;
        int occ;
        @(negedge clk);
        redirect_valid = redir; redirect_pc = rpc; if_ready = ifr; mem_req_ready = mrdy;
        resp_now = 0;
        if (mem_pend && mem_wait == 0) begin
            resp_now = 1; mem_resp_data = instr_of(mem_addr);
        end else if (!mem_pend && spur_en && $urandom_range(0, 7) == 0) begin
            resp_now = 1; mem_resp_data = $urandom;
        end else begin
            mem_resp_data = $urandom;
        end
        mem_resp_valid = resp_now;
        #1;
        s_req_valid = mem_req_valid; s_req_addr = mem_req_addr;
        s_if_valid = if_valid; s_if_pc = if_pc; s_if_instr = if_instr;

        exp_if_v  = (q.size() > 0) && !redir;
        pop_m     = exp_if_v && ifr;
        resp_hit  = resp_now && m_out;
        can_st    = !m_out || (resp_hit && !m_kill);
        occ       = q.size() + ((m_out && !m_kill) ? 1 : 0) - (pop_m ? 1 : 0);
        exp_req_v = !redir && can_st && (occ < DEPTH);

        checks++;
        if (s_if_valid !== exp_if_v) begin
            errors++; $display("FAIL if_valid t=%0t got %b want %b", $time, s_if_valid, exp_if_v);
        end
        if (exp_if_v) begin
            checks++;
            if (s_if_pc !== q[0].pc || s_if_instr !== q[0].instr) begin
                errors++;
                $display("FAIL if_head t=%0t got %h/%h want %h/%h", $time, s_if_pc, s_if_instr, q[0].pc, q[0].instr);
            end
        end
        checks++;
        if (s_req_valid !== exp_req_v) begin
            errors++; $display("FAIL req_valid t=%0t got %b want %b", $time, s_req_valid, exp_req_v);
        end
        if (exp_req_v) begin
            checks++;
            if (s_req_addr !== m_pc) begin
                errors++; $display("FAIL req_addr t=%0t got %h want %h", $time, s_req_addr, m_pc);
            end
        end

        if (pop_m) void'(q.pop_front());
        if (redir) begin
            q.delete();
            m_pc = rpc & ~64'h3;
            if (resp_hit) m_out = 0;
            else if (m_out) m_kill = 1;
        end else begin
            if (resp_hit) begin
                if (!m_kill) q.push_back('{m_out_addr, instr_of(m_out_addr)});
                m_out = 0; m_kill = 0;
            end
            if (exp_req_v && mrdy) begin
                m_out = 1; m_kill = 0; m_out_addr = m_pc; m_pc = m_pc + 64'd4;
            end
        end

        if (mem_pend) begin
            if (resp_now) mem_pend = 0;
            else mem_wait--;
        end
        if (s_req_valid && mrdy) begin
            mem_pend = 1; mem_addr = s_req_addr;
            mem_wait = $urandom_range(lat_lo, lat_hi) - 1;
            handshakes++;
        end
        if (s_if_valid && ifr) pops++;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++;
            if (mem_req_valid !== 1'b0 || if_valid !== 1'b0 || mem_req_addr !== RPC) begin
                errors++;
                $display("FAIL reset_outputs req_valid=%b if_valid=%b addr=%h want 0 0 %h",
                         mem_req_valid, if_valid, mem_req_addr, RPC);
            end
        end
    endtask

    task automatic test_stream();
        do_reset();
        lat_lo = 1; lat_hi = 1; spur_en = 0;
        for (int c = 0; c < 12; c++) begin
            step(0, '0, 1, 1);
            if (c == 0) begin
                checks++;
                if (s_req_valid !== 1'b1 || s_req_addr !== RPC) begin
                    errors++; $display("FAIL stream_first_req got %b/%h want 1/%h", s_req_valid, s_req_addr, RPC);
                end
            end
            if (c >= 2) begin
                checks++;
                if (s_if_valid !== 1'b1 || s_if_pc !== RPC + 64'(4 * (c - 2))) begin
                    errors++;
                    $display("FAIL stream_if_pc c=%0d got %b/%h want 1/%h", c, s_if_valid, s_if_pc, RPC + 64'(4 * (c - 2)));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int          hs0;
        bit          seen;
        logic [63:0] first_pc;
        logic [63:0] popped[$];
        do_reset();
        lat_lo = 1; lat_hi = 1; spur_en = 0;
        hs0 = handshakes; seen = 0; first_pc = '0;
        for (int c = 0; c < 10; c++) begin
            step(0, '0, 0, 1);
            if (s_if_valid) begin
                if (!seen) begin
                    seen = 1; first_pc = s_if_pc;
                end else begin
                    checks++;
                    if (s_if_pc !== first_pc) begin
                        errors++; $display("FAIL hold_if_pc got %h want %h", s_if_pc, first_pc);
                    end
                end
            end
        end
        checks++;
        if (handshakes - hs0 != DEPTH) begin
            errors++; $display("FAIL hold_requests got %0d want %0d", handshakes - hs0, DEPTH);
        end
        checks++;
        if (s_req_valid !== 1'b0) begin
            errors++; $display("FAIL hold_req_valid got %b want 0", s_req_valid);
        end
        for (int c = 0; c < 12; c++) begin
            step(0, '0, 1, 1);
            if (s_if_valid) popped.push_back(s_if_pc);
        end
        checks++;
        if (popped.size() < 6) begin
            errors++; $display("FAIL drain_count got %0d want >=6", popped.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (popped[k] !== RPC + 64'(4 * k)) begin
                    errors++; $display("FAIL drain_order k=%0d got %h want %h", k, popped[k], RPC + 64'(4 * k));
                end
            end
        end
    endtask

    task automatic test_redirect_drop();
        bit found = 0;
        bit got = 0;
        do_reset();
        lat_lo = 3; lat_hi = 3; spur_en = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_out && !m_kill && m_out_addr == 64'h1008 && mem_pend && mem_wait > 0) found = 1;
            else step(0, '0, 1, 1);
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL drop_setup got 0 want 1 (no outstanding 0x1008)");
            return;
        end
        step(1, 64'h2002, 1, 1);
        checks++;
        if (s_if_valid !== 1'b0) begin
            errors++; $display("FAIL drop_kill got %b want 0", s_if_valid);
        end
        for (int i = 0; i < 10 && !got; i++) begin
            step(0, '0, 1, 1);
            if (s_if_valid && s_if_pc == 64'h1008) begin
                checks++; errors++; $display("FAIL drop_discard got %h want none", s_if_pc);
            end
            if (s_req_valid) begin
                got = 1;
                checks++;
                if (s_req_addr !== 64'h2000) begin
                    errors++; $display("FAIL drop_new_addr got %h want %h", s_req_addr, 64'h2000);
                end
            end
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL drop_timeout got 0 want 1 (no request after redirect)");
        end
    endtask

    task automatic test_redirect_resp();
        bit found = 0;
        do_reset();
        lat_lo = 2; lat_hi = 2; spur_en = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_out && !m_kill && mem_pend && mem_wait == 0 && q.size() > 0) found = 1;
            else step(0, '0, 0, 1);
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL resp_setup got 0 want 1 (no response cycle found)");
            return;
        end
        step(1, 64'h3000, 0, 1);
        step(0, '0, 0, 1);
        checks++;
        if (s_req_valid !== 1'b1 || s_req_addr !== 64'h3000 || s_if_valid !== 1'b0) begin
            errors++;
            $display("FAIL resp_redirect got req=%b addr=%h ifv=%b want 1 3000 0", s_req_valid, s_req_addr, s_if_valid);
        end
        step(0, '0, 0, 1);
        checks++;
        if (s_if_valid !== 1'b0) begin
            errors++; $display("FAIL resp_flushed got %b want 0", s_if_valid);
        end
    endtask

    task automatic test_wrap();
        logic [63:0] reqs[$];
        logic [63:0] pcs[$];
        logic [31:0] instrs[$];
        bit          pend = 0;
        logic [63:0] paddr = '0;
        @(negedge clk);
        w_reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            w_resp_valid = pend;
            w_resp_data  = instr_of(paddr);
            #1;
            if (w_if_valid) begin
                pcs.push_back(w_if_pc); instrs.push_back(w_if_instr);
            end
            pend = 0;
            if (w_req_valid && w_req_ready) begin
                reqs.push_back(w_req_addr); pend = 1; paddr = w_req_addr;
            end
            @(negedge clk);
        end
        checks++;
        if (reqs.size() < 3 || pcs.size() < 2) begin
            errors++; $display("FAIL wrap_count got %0d/%0d want >=3/>=2", reqs.size(), pcs.size());
            return;
        end
        checks++;
        if (reqs[0] !== WRAP_PC || reqs[1] !== 64'h0 || reqs[2] !== 64'h4) begin
            errors++; $display("FAIL wrap_req got %h %h %h want %h 0 4", reqs[0], reqs[1], reqs[2], WRAP_PC);
        end
        checks++;
        if (pcs[0] !== WRAP_PC || pcs[1] !== 64'h0 || instrs[1] !== instr_of(64'h0)) begin
            errors++;
            $display("FAIL wrap_if got %h %h/%h want %h 0/%h", pcs[0], pcs[1], instrs[1], WRAP_PC, instr_of(64'h0));
        end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        bit got = 0;
        do_reset();
        lat_lo = 3; lat_hi = 3; spur_en = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (m_out && !m_kill && q.size() > 0 && mem_pend && mem_wait > 0) found = 1;
            else step(0, '0, 0, 1);
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL midreset_setup got 0 want 1 (WAIT with data not reached)");
            return;
        end
        @(negedge clk);
        reset = 1'b1; if_ready = 1'b1; mem_req_ready = 1'b1; redirect_valid = 1'b0; mem_resp_valid = 1'b0;
        #1;
        checks++;
        if (mem_req_valid !== 1'b0 || if_valid !== 1'b0 || mem_req_addr !== RPC) begin
            errors++;
            $display("FAIL midreset_clear got %b/%b/%h want 0/0/%h", mem_req_valid, if_valid, mem_req_addr, RPC);
        end
        model_reset();
        mem_wait = 0;
        mem_req_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step(0, '0, 1, 1);
            if (s_if_valid) begin
                got = 1;
                checks++;
                if (s_if_pc !== RPC || s_if_instr !== instr_of(RPC)) begin
                    errors++;
                    $display("FAIL midreset_restart got %h/%h want %h/%h", s_if_pc, s_if_instr, RPC, instr_of(RPC));
                end
            end
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL midreset_timeout got 0 want 1 (no instruction after reset)");
        end
    endtask

    task automatic test_random();
        do_reset();
        lat_lo = 1; lat_hi = 4; spur_en = 1;
        for (int c = 0; c < 800; c++) begin
            step($urandom_range(0, 11) == 0, {$urandom, $urandom},
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end
        spur_en = 0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_resp();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "simulation did not complete");
    end

endmodule
